// File: rtl/sd_spi_responder_if.sv
// SPI link and byte-wide backing-store bus shared by the SD responder and its host side.
interface sd_spi_responder_if #(
    parameter int ADDR_W = 16
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        mem_wdata;
    logic              mem_we;

    // Host side: drives the SPI clock/select/data and supplies memory read data.
    modport master (
        output sclk, cs, mosi, mem_rdata,
        input  miso, mem_addr, mem_wdata, mem_we
    );

    // Card side: answers on miso and owns the memory address/write strobe.
    modport slave (
        input  sclk, cs, mosi, mem_rdata,
        output miso, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes command frames, answers R1 and moves
// 512-byte blocks between the host and an external byte-wide memory.
// SPI pins are oversampled on clk, so clk must run at least 8x sclk.
module sd_spi_responder #(
    parameter int ADDR_W       = 16,
    parameter int ACMD41_POLLS = 2,
    parameter int BUSY_BYTES   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    sd_spi_responder_if.slave bus,
    output logic              card_ready,
    output logic [5:0]        last_cmd
);

    typedef enum logic [3:0] {
        HUNT, CMD, NCR, RESP,
        RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;

    localparam logic [7:0]        POLL_LIMIT = 8'(ACMD41_POLLS);
    localparam logic [9:0]        BUSY_LAST  = 10'(BUSY_BYTES - 1);
    localparam logic [9:0]        BLOCK_LAST = 10'd511;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t state_q, state_d;

    logic              sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_s3_q, sclk_s3_d;
    logic              cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_s3_q, cs_s3_d;
    logic              mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_sr_q, rx_sr_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic              miso_q, miso_d;
    logic [9:0]        byte_cnt_q, byte_cnt_d;
    logic [5:0]        cmd_idx_q, cmd_idx_d;
    logic [31:0]       arg_q, arg_d;
    logic [7:0]        r1_q, r1_d;
    logic              rd_go_q, rd_go_d, wr_go_q, wr_go_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              idle_q, idle_d;
    logic [7:0]        poll_q, poll_d;
    logic              app_q, app_d;
    logic              card_ready_q, card_ready_d;
    logic [5:0]        last_cmd_q, last_cmd_d;

    logic       sclk_rise, sclk_fall, cs_high, cs_fall, byte_done, arg_in_range;
    logic [7:0] rx_byte;

    assign sclk_rise    = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall    = ~sclk_s2_q & sclk_s3_q;
    assign cs_high      = cs_s2_q;
    assign cs_fall      = ~cs_s2_q & cs_s3_q;
    assign rx_byte      = {rx_sr_q, mosi_s2_q};
    assign byte_done    = sclk_rise & ~cs_high & (bit_cnt_q == 3'd7);
    assign arg_in_range = ((arg_q >> ADDR_W) == 32'd0);

    assign bus.miso      = bus.cs ? 1'b1 : miso_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign card_ready    = card_ready_q;
    assign last_cmd      = last_cmd_q;

    // Next-state and datapath: bit shifting on sclk edges, protocol decisions at byte boundaries.
    always_comb begin
        state_d      = state_q;
        sclk_s1_d    = bus.sclk;
        sclk_s2_d    = sclk_s1_q;
        sclk_s3_d    = sclk_s2_q;
        cs_s1_d      = bus.cs;
        cs_s2_d      = cs_s1_q;
        cs_s3_d      = cs_s2_q;
        mosi_s1_d    = bus.mosi;
        mosi_s2_d    = mosi_s1_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        miso_d       = miso_q;
        byte_cnt_d   = byte_cnt_q;
        cmd_idx_d    = cmd_idx_q;
        arg_d        = arg_q;
        r1_d         = r1_q;
        rd_go_d      = rd_go_q;
        wr_go_d      = wr_go_q;
        base_d       = base_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        idle_d       = idle_q;
        poll_d       = poll_q;
        app_d        = app_q;
        card_ready_d = card_ready_q;
        last_cmd_d   = last_cmd_q;

        if (cs_high || cs_fall) begin
            bit_cnt_d = 3'd0;
        end

        if (cs_high) begin
            // Deselect abandons any frame or block but keeps the init state.
            state_d    = HUNT;
            tx_sr_d    = 8'hFF;
            miso_d     = 1'b1;
            byte_cnt_d = 10'd0;
            rd_go_d    = 1'b0;
            wr_go_d    = 1'b0;
        end else begin
            if (sclk_fall) begin
                miso_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b1};
            end
            if (sclk_rise) begin
                rx_sr_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                tx_sr_d = 8'hFF;
                case (state_q)
                    HUNT: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            cmd_idx_d  = rx_byte[5:0];
                            byte_cnt_d = 10'd0;
                            state_d    = CMD;
                        end
                    end
                    CMD: begin
                        if (byte_cnt_q < 10'd4) begin
                            arg_d      = {arg_q[23:0], rx_byte};
                            byte_cnt_d = byte_cnt_q + 10'd1;
                        end else begin
                            // Last byte is the CRC, which is ignored; decode now.
                            state_d    = NCR;
                            last_cmd_d = cmd_idx_q;
                            app_d      = 1'b0;
                            rd_go_d    = 1'b0;
                            wr_go_d    = 1'b0;
                            case (cmd_idx_q)
                                6'd0: begin
                                    card_ready_d = 1'b0;
                                    idle_d       = 1'b1;
                                    poll_d       = 8'd0;
                                    r1_d         = 8'h01;
                                end
                                6'd55: begin
                                    r1_d  = {7'b0, idle_q};
                                    app_d = 1'b1;
                                end
                                6'd41: begin
                                    if (!app_q) begin
                                        r1_d = 8'h04 | {7'b0, idle_q};
                                    end else if (poll_q < POLL_LIMIT) begin
                                        poll_d = poll_q + 8'd1;
                                        r1_d   = 8'h01;
                                    end else begin
                                        idle_d       = 1'b0;
                                        card_ready_d = 1'b1;
                                        r1_d         = 8'h00;
                                    end
                                end
                                6'd17, 6'd24: begin
                                    if (idle_q) begin
                                        r1_d = 8'h05;
                                    end else if (!arg_in_range) begin
                                        r1_d = 8'h40;
                                    end else begin
                                        r1_d    = 8'h00;
                                        rd_go_d = (cmd_idx_q == 6'd17);
                                        wr_go_d = (cmd_idx_q == 6'd24);
                                        base_d  = {arg_q[ADDR_W-1:9], 9'd0};
                                    end
                                end
                                default: r1_d = 8'h04 | {7'b0, idle_q};
                            endcase
                        end
                    end
                    NCR: begin
                        tx_sr_d = r1_q;
                        state_d = RESP;
                    end
                    RESP: begin
                        if (rd_go_q)      state_d = RD_GAP;
                        else if (wr_go_q) state_d = WR_TOKEN;
                        else              state_d = HUNT;
                        rd_go_d = 1'b0;
                        wr_go_d = 1'b0;
                    end
                    RD_GAP: begin
                        // Issue the first read early so it is ready when the token ends.
                        tx_sr_d    = 8'hFE;
                        mem_addr_d = base_q;
                        state_d    = RD_TOKEN;
                    end
                    RD_TOKEN: begin
                        tx_sr_d    = bus.mem_rdata;
                        mem_addr_d = mem_addr_q + ADDR_ONE;
                        byte_cnt_d = 10'd0;
                        state_d    = RD_DATA;
                    end
                    RD_DATA: begin
                        if (byte_cnt_q == BLOCK_LAST) begin
                            byte_cnt_d = 10'd0;
                            state_d    = RD_CRC;
                        end else begin
                            tx_sr_d    = bus.mem_rdata;
                            byte_cnt_d = byte_cnt_q + 10'd1;
                            if (mem_addr_q[8:0] != 9'h1FF) begin
                                mem_addr_d = mem_addr_q + ADDR_ONE;
                            end
                        end
                    end
                    RD_CRC: begin
                        if (byte_cnt_q == 10'd0) byte_cnt_d = 10'd1;
                        else                     state_d = HUNT;
                    end
                    WR_TOKEN: begin
                        if (rx_byte == 8'hFE) begin
                            byte_cnt_d = 10'd0;
                            state_d    = WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = rx_byte;
                        mem_addr_d  = base_q + ADDR_W'(byte_cnt_q);
                        if (byte_cnt_q == BLOCK_LAST) begin
                            byte_cnt_d = 10'd0;
                            state_d    = WR_CRC;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 10'd1;
                        end
                    end
                    WR_CRC: begin
                        if (byte_cnt_q == 10'd0) begin
                            byte_cnt_d = 10'd1;
                        end else begin
                            tx_sr_d = 8'h05;
                            state_d = WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        tx_sr_d    = 8'h00;
                        byte_cnt_d = 10'd0;
                        state_d    = WR_BUSY;
                    end
                    WR_BUSY: begin
                        if (byte_cnt_q == BUSY_LAST) begin
                            state_d = HUNT;
                        end else begin
                            tx_sr_d    = 8'h00;
                            byte_cnt_d = byte_cnt_q + 10'd1;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= HUNT;
        else          state_q <= state_d;
    end

    // Synchronizers, shift registers, card status and memory interface registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1_q    <= 1'b0;
            sclk_s2_q    <= 1'b0;
            sclk_s3_q    <= 1'b0;
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            cs_s3_q      <= 1'b1;
            mosi_s1_q    <= 1'b1;
            mosi_s2_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
            rx_sr_q      <= 7'd0;
            tx_sr_q      <= 8'hFF;
            miso_q       <= 1'b1;
            byte_cnt_q   <= 10'd0;
            cmd_idx_q    <= 6'd0;
            arg_q        <= 32'd0;
            r1_q         <= 8'hFF;
            rd_go_q      <= 1'b0;
            wr_go_q      <= 1'b0;
            base_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            mem_we_q     <= 1'b0;
            idle_q       <= 1'b1;
            poll_q       <= 8'd0;
            app_q        <= 1'b0;
            card_ready_q <= 1'b0;
            last_cmd_q   <= 6'd0;
        end else begin
            sclk_s1_q    <= sclk_s1_d;
            sclk_s2_q    <= sclk_s2_d;
            sclk_s3_q    <= sclk_s3_d;
            cs_s1_q      <= cs_s1_d;
            cs_s2_q      <= cs_s2_d;
            cs_s3_q      <= cs_s3_d;
            mosi_s1_q    <= mosi_s1_d;
            mosi_s2_q    <= mosi_s2_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            miso_q       <= miso_d;
            byte_cnt_q   <= byte_cnt_d;
            cmd_idx_q    <= cmd_idx_d;
            arg_q        <= arg_d;
            r1_q         <= r1_d;
            rd_go_q      <= rd_go_d;
            wr_go_q      <= wr_go_d;
            base_q       <= base_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            idle_q       <= idle_d;
            poll_q       <= poll_d;
            app_q        <= app_d;
            card_ready_q <= card_ready_d;
            last_cmd_q   <= last_cmd_d;
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: acts as the SPI host and the backing memory,
// with scoreboards for miso bytes and memory writes.
module tb_sd_spi_responder;

    localparam int ADDR_W = 16;
    localparam int HALF   = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       card_ready;
    logic [5:0] last_cmd;

    sd_spi_responder_if #(.ADDR_W(ADDR_W)) ifc();

    sd_spi_responder #(
        .ADDR_W(ADDR_W),
        .ACMD41_POLLS(2),
        .BUSY_BYTES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ifc.slave),
        .card_ready(card_ready),
        .last_cmd(last_cmd)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    logic [7:0]  mem [0:65535];
    logic        preload = 1'b0;
    logic [7:0]  exp_q [$];
    logic [23:0] wr_q [$];
    logic [23:0] wr_exp;
    logic [7:0]  rx_byte;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Backing memory: preload pattern byte i = i[7:0], synchronous read one clk after address.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 65536; i++) mem[i] <= i[7:0];
        end else if (ifc.mem_we) begin
            mem[ifc.mem_addr] <= ifc.mem_wdata;
        end
        ifc.mem_rdata <= mem[ifc.mem_addr];
    end

    // Write scoreboard: every strobe must match the next expected address/data pair.
    always @(negedge clk) begin
        if (reset_n && ifc.mem_we === 1'b1) begin
            wr_count++;
            if (wr_q.size() == 0) begin
                checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_exp = wr_q.pop_front();
                checkOutput("wr_addr", 32'(ifc.mem_addr), 32'(wr_exp[23:8]));
                checkOutput("wr_data", 32'(ifc.mem_wdata), 32'(wr_exp[7:0]));
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic spiByte(input logic [7:0] txb, output logic [7:0] rxb);
        for (int i = 7; i >= 0; i--) begin
            ifc.mosi = txb[i];
            #HALF;
            rxb[i] = ifc.miso;
            ifc.sclk = 1'b1;
            #HALF;
            ifc.sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] txb, input bit chk, input logic [7:0] expb, input string tag);
        logic [7:0] r;
        if (chk) exp_q.push_back(expb);
        spiByte(txb, r);
        rx_byte = r;
        if (chk) checkOutput(tag, 32'(r), 32'(exp_q.pop_front()));
    endtask

    task automatic csLow();
        ifc.cs = 1'b0;
        #HALF;
    endtask

    task automatic csHigh();
        #HALF;
        ifc.cs = 1'b1;
        #(4 * HALF);
    endtask

    task automatic sendCommand(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1, input string tag);
        applyStimulus({2'b01, idx}, 1'b1, 8'hFF, "cmd_miso_idle");
        applyStimulus(arg[31:24], 1'b1, 8'hFF, "cmd_miso_idle");
        applyStimulus(arg[23:16], 1'b1, 8'hFF, "cmd_miso_idle");
        applyStimulus(arg[15:8],  1'b1, 8'hFF, "cmd_miso_idle");
        applyStimulus(arg[7:0],   1'b1, 8'hFF, "cmd_miso_idle");
        applyStimulus(8'h95,      1'b1, 8'hFF, "cmd_miso_idle");
        applyStimulus(8'hFF,      1'b1, 8'hFF, "ncr");
        applyStimulus(8'hFF,      1'b1, r1,    tag);
    endtask

    initial begin
        ifc.sclk = 1'b0;
        ifc.cs   = 1'b1;
        ifc.mosi = 1'b1;
        reset_n  = 1'b0;
        preload  = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        checkOutput("rst_miso", 32'(ifc.miso), 32'd1);
        checkOutput("rst_mem_we", 32'(ifc.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(ifc.mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(ifc.mem_wdata), 32'd0);
        checkOutput("rst_card_ready", 32'(card_ready), 32'd0);
        checkOutput("rst_last_cmd", 32'(last_cmd), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // CMD0 puts the card in idle.
        csLow();
        sendCommand(6'd0, 32'd0, 8'h01, "cmd0_r1");
        csHigh();
        checkOutput("cmd0_card_ready", 32'(card_ready), 32'd0);
        checkOutput("cmd0_last_cmd", 32'(last_cmd), 32'd0);

        // Read before initialisation is refused and has no data phase.
        csLow();
        sendCommand(6'd17, 32'd0, 8'h05, "cmd17_idle_r1");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "cmd17_idle_nodata");
        csHigh();

        // CMD55+ACMD41 three times: two polls answered idle, third completes init.
        for (int k = 0; k < 3; k++) begin
            csLow();
            sendCommand(6'd55, 32'd0, 8'h01, "cmd55_r1");
            sendCommand(6'd41, 32'h40000000, (k < 2) ? 8'h01 : 8'h00, "acmd41_r1");
            csHigh();
            checkOutput("acmd41_card_ready", 32'(card_ready), (k == 2) ? 32'd1 : 32'd0);
        end

        // Unsupported command after init.
        csLow();
        sendCommand(6'd9, 32'd0, 8'h04, "cmd9_r1");
        csHigh();
        checkOutput("cmd9_last_cmd", 32'(last_cmd), 32'd9);

        // Full block read from 0x200.
        csLow();
        sendCommand(6'd17, 32'h00000200, 8'h00, "rd_r1");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "rd_gap");
        applyStimulus(8'hFF, 1'b1, 8'hFE, "rd_token");
        for (int i = 0; i < 512; i++) applyStimulus(8'hFF, 1'b1, i[7:0], "rd_data");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "rd_crc");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "rd_crc");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "rd_after");
        csHigh();
        checkOutput("rd_addr_end", 32'(ifc.mem_addr), 32'h03FF);

        // Out-of-range read: R1 0x40 and no token.
        csLow();
        sendCommand(6'd17, 32'h00010000, 8'h40, "oor_r1");
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 1'b1, 8'hFF, "oor_no_token");
        csHigh();

        // Full block write to 0x400; one data byte looks like a command start.
        csLow();
        sendCommand(6'd24, 32'h00000400, 8'h00, "wr_r1");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "wr_wait");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "wr_wait");
        applyStimulus(8'hFE, 1'b1, 8'hFF, "wr_wait");
        for (int i = 0; i < 512; i++) begin
            wr_addr = 16'h0400 + 16'(i);
            wr_data = (i == 5) ? 8'h40 : 8'hA5;
            wr_q.push_back({wr_addr, wr_data});
            applyStimulus(wr_data, 1'b1, 8'hFF, "wr_data_miso");
        end
        applyStimulus(8'h12, 1'b1, 8'hFF, "wr_crc_miso");
        applyStimulus(8'h34, 1'b1, 8'hFF, "wr_crc_miso");
        applyStimulus(8'hFF, 1'b1, 8'h05, "wr_resp");
        for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 1'b1, 8'h00, "wr_busy");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "wr_done");
        csHigh();
        checkOutput("wr_count", 32'(wr_count), 32'd512);
        checkOutput("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        checkOutput("wr_mem_first", 32'(mem[16'h0400]), 32'hA5);
        checkOutput("wr_mem_start_pat", 32'(mem[16'h0405]), 32'h40);
        checkOutput("wr_mem_last", 32'(mem[16'h05FF]), 32'hA5);
        checkOutput("wr_mem_untouched", 32'(mem[16'h0600]), 32'h00);
        checkOutput("wr_last_cmd", 32'(last_cmd), 32'd24);

        // Abort a read with cs after 100 bytes, then a fresh read starts from byte 0.
        csLow();
        sendCommand(6'd17, 32'h00000200, 8'h00, "rd_abort_r1");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "rd_abort_gap");
        applyStimulus(8'hFF, 1'b1, 8'hFE, "rd_abort_token");
        for (int i = 0; i < 100; i++) applyStimulus(8'hFF, 1'b1, i[7:0], "rd_abort_data");
        csHigh();
        csLow();
        sendCommand(6'd17, 32'h00000200, 8'h00, "rd2_r1");
        applyStimulus(8'hFF, 1'b1, 8'hFF, "rd2_gap");
        applyStimulus(8'hFF, 1'b1, 8'hFE, "rd2_token");
        for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 1'b1, i[7:0], "rd2_data");
        csHigh();
        checkOutput("abort_card_ready", 32'(card_ready), 32'd1);

        // Reset in the middle of a write: committed bytes stay, card drops back to uninitialised.
        csLow();
        sendCommand(6'd24, 32'h00000600, 8'h00, "wr2_r1");
        applyStimulus(8'hFE, 1'b1, 8'hFF, "wr2_token");
        for (int i = 0; i < 10; i++) begin
            wr_addr = 16'h0600 + 16'(i);
            wr_q.push_back({wr_addr, 8'h3C});
            applyStimulus(8'h3C, 1'b1, 8'hFF, "wr2_data_miso");
        end
        #HALF;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_mem_we", 32'(ifc.mem_we), 32'd0);
        checkOutput("midrst_card_ready", 32'(card_ready), 32'd0);
        checkOutput("midrst_last_cmd", 32'(last_cmd), 32'd0);
        checkOutput("midrst_wr_count", 32'(wr_count), 32'd522);
        checkOutput("midrst_mem_kept", 32'(mem[16'h0609]), 32'h3C);
        ifc.cs = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- Synthesizable SPI-mode SD card responder: the card end of the link that sd_controller drives.
- Used in simulation and on-board loopback so the SD read/write path can be tested without a physical card.
- Decodes 48-bit command frames, returns R1 responses, and streams 512-byte blocks to or from an external byte-wide block memory.
- Oversamples sclk/cs/mosi on the system clock.

Parameters:
ADDR_W, 16, backing-store byte address width; capacity 2^ADDR_W bytes.
ACMD41_POLLS, 2, ACMD41 attempts answered 0x01 before 0x00 is returned.
BUSY_BYTES, 4, 0x00 busy bytes sent after a write data-response.

Ports:
clk  input  1  system clock; must be >= 8x sclk.
reset_n  input  1  asynchronous, active-low reset.
sclk  input  1  SPI clock from host (mode 0).
cs  input  1  chip select, active low.
mosi  input  1  host-to-card data.
miso  output  1  card-to-host data; 1 whenever cs is high.
mem_addr  output  ADDR_W  backing-store byte address.
mem_rdata  input  8  read data, valid 1 clk after mem_addr.
mem_wdata  output  8  write data.
mem_we  output  1  one-cycle write strobe.
card_ready  output  1  high after a successful ACMD41 (left idle).
last_cmd  output  6  index of the last decoded command.

Behaviour:
- Reset values: miso=1, mem_we=0, mem_addr=0, mem_wdata=0, card_ready=0, last_cmd=0. Internal state: IDLE_STATE=1, poll count=0, FSM=HUNT.
- Async reset mid-transfer aborts all activity. Memory writes already committed are kept.
- Input sync and sampling:
  - sclk, cs, mosi each pass through 2-flop synchronizers; sclk edges are then detected.
  - mosi is shifted in MSB-first on each rising sclk edge.
  - miso updates on each falling sclk edge.
- Bit counter and byte framing:
  - Bit counter clears on cs falling edge and whenever cs is high.
  - The 8th rising edge is a byte boundary; the next tx byte is selected there.
  - The following falling edge drives tx[7] onto miso. Idle tx byte is 0xFF.
- FSM states: HUNT, CMD, NCR, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
- HUNT / CMD:
  - In HUNT, a received byte with bits[7:6]=01 starts a frame; go to CMD.
  - CMD collects 5 more bytes (arg[31:0] MSB-first, then CRC byte). CRC is ignored.
  - After the 6th byte: last_cmd is updated and the R1 response is computed.
- NCR: one 0xFF byte, then RESP sends the R1 byte.
- R1 rules:
  - CMD0: clear card_ready, IDLE=1, poll=0; R1=0x01.
  - CMD55: R1={7'b0,IDLE}; arms the app-command flag for the next frame only.
  - ACMD41 (CMD41 with flag armed): while poll<ACMD41_POLLS, increment poll and return R1=0x01. Otherwise IDLE=0, card_ready=1, R1=0x00.
  - CMD17/CMD24 while IDLE=1: R1=0x05.
  - CMD17/CMD24 with arg >= 2^ADDR_W: R1=0x40, no data phase.
  - Any other index: R1=0x04 | IDLE.
- After RESP: return to HUNT unless a valid CMD17/CMD24 is in progress. Block base = arg with arg[8:0] forced to 0.
- Read path (CMD17): RD_GAP sends one 0xFF, RD_TOKEN sends 0xFE.
  - RD_DATA sends 512 bytes from mem_addr=base+i.
  - Each byte's read is issued at the previous byte boundary (prefetch).
  - RD_CRC sends 0xFF,0xFF, then HUNT.
- Write path (CMD24): WR_TOKEN sends 0xFF until a received byte equals 0xFE.
  - WR_DATA: each received byte gives one-cycle mem_we, mem_wdata=byte, mem_addr=base+i, for i=0..511.
  - WR_CRC discards 2 bytes.
  - WR_RESP sends 0x05.
  - WR_BUSY sends BUSY_BYTES of 0x00, then HUNT (0xFF).
- Address arithmetic: base+i is computed in ADDR_W bits. The block never wraps because the base is range-checked and 512-aligned.
- cs rising mid-frame or mid-block: FSM returns to HUNT, partial byte is discarded, and IDLE/card_ready/poll are kept.
- A start pattern seen during data or CRC phases is treated as data, not as a command.

Test Plan:
- Reset, then CMD0 (40 00 00 00 00 95) -> bytes FF,01 on miso; card_ready=0; last_cmd=0.
- CMD55+ACMD41 repeated 3 times with ACMD41_POLLS=2 -> ACMD41 R1 sequence 01,01,00; card_ready rises after the 3rd.
- Memory preloaded with byte i = i[7:0]; CMD17 arg=0x00000200 -> R1 00, FF, FE, then 00..FF twice (512 bytes), FF, FF; mem_addr spans 0x0200..0x03FF.
- CMD24 arg=0x00000400, host sends FE plus 512 bytes of 0xA5 plus 2 CRC -> 512 mem_we pulses at 0x0400..0x05FF; response 05; then exactly 4 bytes 00; then FF.
- CMD17 before init -> R1 05. CMD17 arg=0x00010000 (ADDR_W=16) -> R1 40 and no FE token. CMD9 after init -> R1 04.
- cs raised after 100 data bytes of a CMD17, then a new CMD17 -> fresh FE token and data from byte 0. reset_n pulsed mid-CMD24 -> mem_we=0 immediately and card_ready=0.
